// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions and hex glyph table.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;
  localparam int unsigned SEG_W  = 8;

  // Glyphs for 0..F, bits {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder with decimal point pass-through.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       value,
  input  logic             dp,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c               = '0;
    seg_c[SEG_G:SEG_A]  = SEG_TABLE[value];
    seg_c[SEG_DP]       = dp;
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with frame-synchronous double-buffered data.
// Optional leading-zero blanking is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] numar,
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [SEG_W-1:0]      seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int unsigned NUM_W = 4 * N_DIGITS;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [NUM_W-1:0]    pend_num, shad_num;
  logic [N_DIGITS-1:0] pend_dp, shad_dp;
  logic [PRE_W-1:0]    presc;
  logic [IDX_W-1:0]    idx;

  logic             tc_c, last_c, boundary_c;
  logic [3:0]       sel_val_c;
  logic             sel_dp_c, sel_blank_c;
  logic [SEG_W-1:0] dec_seg_c, seg_next_c;

  assign tc_c       = enable && (presc == PRE_W'(PRESCALE - 1));
  assign last_c     = (idx == IDX_W'(N_DIGITS - 1));
  assign boundary_c = tc_c && last_c;

  // Pick the shadow digit currently addressed by idx.
  always_comb begin
    sel_val_c = 4'h0;
    sel_dp_c  = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_val_c = shad_num[4*i +: 4];
        sel_dp_c  = shad_dp[i];
      end
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    logic zero_run;
    zero_run    = 1'b1;
    sel_blank_c = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (shad_num[4*i +: 4] == 4'h0);
      if ((i > 0) && zero_run && (idx == IDX_W'(i))) sel_blank_c = 1'b1;
    end
  end
`else
  assign sel_blank_c = 1'b0;
`endif

  seg7_decode u_decode (
    .value (sel_val_c),
    .dp    (sel_dp_c),
    .seg_c (dec_seg_c)
  );

  assign seg_next_c = sel_blank_c ? {dec_seg_c[SEG_DP], 7'h00} : dec_seg_c;

  // Pending captures every load; shadow only refreshes between frames or while dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_num <= '0;
      pend_dp  <= '0;
      shad_num <= '0;
      shad_dp  <= '0;
    end else begin
      if (!enable || boundary_c) begin
        shad_num <= pend_num;
        shad_dp  <= pend_dp;
      end
      if (load) begin
        pend_num <= numar;
        pend_dp  <= dp_in;
      end
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc_c) begin
      presc <= '0;
      idx   <= last_c ? '0 : idx + IDX_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Registered display outputs, one cycle behind idx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      seg        <= '0;
      an         <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next_c;
      an         <= N_DIGITS'(1) << idx;
      frame_done <= boundary_c;
    end
  end

endmodule
